// File: rtl/wb_pdm_pkg.sv
// rtl/wb_pdm_pkg.sv - register map, CTRL bit positions and address decode for the PDM bank
package wb_pdm_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DIV_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIV    = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_LEVEL0 = 5'd2;

  localparam int CTRL_INVERT_BIT = 16;
  localparam int CTRL_COMMIT_BIT = 31;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_DIV,
    SEL_LEVEL
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] adr, input int channels);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (adr == ADDR_CTRL) begin
      sel = SEL_CTRL;
    end else if (adr == ADDR_DIV) begin
      sel = SEL_DIV;
    end else if ((int'(adr) >= int'(ADDR_LEVEL0)) && (int'(adr) < int'(ADDR_LEVEL0) + channels)) begin
      sel = SEL_LEVEL;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_pdm_modulator.sv
// rtl/wb_pdm_modulator.sv - one first-order PDM channel; the accumulator carry is the bitstream
module wb_pdm_modulator #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_tick,
  input  logic         i_enable,
  input  logic [N-1:0] i_level,
  output logic         o_out
);

  logic [N:0] r_acc;

  // Holding the accumulator at zero while disabled makes every enable start from a clean phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (!i_enable) begin
      r_acc <= '0;
    end else if (i_tick) begin
      r_acc <= {1'b0, r_acc[N-1:0]} + {1'b0, i_level};
    end
  end

  assign o_out = r_acc[N];

endmodule

// File: rtl/wb_pdm_multi.sv
// rtl/wb_pdm_multi.sv - Wishbone pipelined slave driving a bank of PDM channels with shared prescaler
module wb_pdm_multi
  import wb_pdm_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int BIT_RESOLUTION = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic [CHANNELS-1:0] pdm_o
);

  localparam int N = BIT_RESOLUTION;

  logic                r_ack;
  logic [DATA_W-1:0]   r_dat;
  logic [CHANNELS-1:0] r_enable;
  logic                r_invert;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_cnt;
  logic [N-1:0]        r_shadow [CHANNELS];
  logic [N-1:0]        r_active [CHANNELS];

  logic                w_req;
  logic                w_wr;
  logic                w_div_wr;
  logic                w_commit;
  logic                w_tick;
  reg_sel_e            w_sel;
  logic [ADDR_W-1:0]   w_idx;
  logic [DATA_W-1:0]   w_rdata;
  logic [CHANNELS-1:0] w_acc_msb;
  logic                w_unused;

  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_wr       = w_req & wb_we_i;
  assign w_sel      = decode_addr(wb_adr_i, CHANNELS);
  assign w_idx      = wb_adr_i - ADDR_LEVEL0;
  assign w_div_wr   = w_wr && (w_sel == SEL_DIV);
  assign w_commit   = w_wr && (w_sel == SEL_CTRL) && wb_dat_i[CTRL_COMMIT_BIT];
  assign w_tick     = (r_cnt == r_div);
  assign w_unused   = ^wb_dat_i;

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_CTRL: begin
        w_rdata[CHANNELS-1:0]   = r_enable;
        w_rdata[CTRL_INVERT_BIT] = r_invert;
      end
      SEL_DIV: w_rdata[DIV_W-1:0] = r_div;
      SEL_LEVEL: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (w_idx == ADDR_W'(k)) w_rdata[N-1:0] = r_shadow[k];
        end
      end
      default: w_rdata = '0;
    endcase
  end

  // Read data is captured at acceptance so it lines up with the single-cycle ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wb_we_i) ? w_rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_enable <= '0;
      r_invert <= 1'b0;
      r_div    <= '0;
    end else if (w_wr) begin
      if (w_sel == SEL_CTRL) begin
        r_enable <= wb_dat_i[CHANNELS-1:0];
        r_invert <= wb_dat_i[CTRL_INVERT_BIT];
      end
      if (w_sel == SEL_DIV) r_div <= wb_dat_i[DIV_W-1:0];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt <= '0;
    end else if (w_div_wr || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Active levels only change on COMMIT, so a tick in the same edge still sees the old values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_wr && (w_sel == SEL_LEVEL) && (w_idx == ADDR_W'(k))) r_shadow[k] <= wb_dat_i[N-1:0];
        if (w_commit) r_active[k] <= r_shadow[k];
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    wb_pdm_modulator #(
      .N(N)
    ) u_mod (
      .i_clk    (wb_clk_i),
      .i_rst_n  (wb_rst_ni),
      .i_tick   (w_tick),
      .i_enable (r_enable[k]),
      .i_level  (r_active[k]),
      .o_out    (w_acc_msb[k])
    );
  end

  assign pdm_o      = w_acc_msb ^ {CHANNELS{r_invert}};
  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat;
  assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_wb_pdm_multi.sv
// tb/tb_wb_pdm_multi.sv - directed self-checking bench for wb_pdm_multi (CHANNELS=4, N=8)
module tb_wb_pdm_multi;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic [3:0]  pdm_o;

  int n_checks = 0;
  int n_errors = 0;

  wb_pdm_multi #(
    .CHANNELS       (4),
    .BIT_RESOLUTION (8)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_stall_o (wb_stall_o),
    .pdm_o      (pdm_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
    @(posedge wb_clk_i); #1;
    check("wr_ack", 32'(wb_ack_o), 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    @(posedge wb_clk_i); #1;
    check({tag, "_ack"}, 32'(wb_ack_o), 32'd1);
    check(tag, wb_dat_o, exp);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    wb_rst_ni = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0;
    #3;
    check("rst_pdm", 32'(pdm_o), 32'd0);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("stall", 32'(wb_stall_o), 32'd0);
    #9 wb_rst_ni = 1'b1;

    wb_read_check("rst_ctrl", 5'd0, 32'd0);
    wb_read_check("rst_div", 5'd1, 32'd0);
    wb_read_check("rst_lvl0", 5'd2, 32'd0);

    // DIV=0, LEVEL0=64, enable ch0 with COMMIT: high on every 4th tick
    wb_write(5'd1, 32'd0);
    wb_write(5'd2, 32'd64);
    wb_write(5'd0, 32'h8000_0001);
    for (int i = 1; i <= 8; i++) begin
      @(posedge wb_clk_i); #1;
      check("div0_pdm0", 32'(pdm_o[0]), 32'((i % 4) == 0));
    end

    // LEVEL1=128 without COMMIT stays silent, then alternates after COMMIT
    wb_write(5'd3, 32'd128);
    wb_write(5'd0, 32'h0000_0003);
    for (int i = 1; i <= 6; i++) begin
      @(posedge wb_clk_i); #1;
      check("nocommit_pdm1", 32'(pdm_o[1]), 32'd0);
    end
    wb_write(5'd0, 32'h8000_0003);
    for (int i = 1; i <= 6; i++) begin
      @(posedge wb_clk_i); #1;
      check("commit_pdm1", 32'(pdm_o[1]), 32'((i % 2) == 0));
    end

    // DIV=3: DIV write edge is D, enable at D+2, ticks at D+4k -> high for k = 16..19 (mod 16)
    wb_write(5'd0, 32'h0000_0000);
    wb_write(5'd1, 32'd3);
    wb_write(5'd0, 32'h0000_0001);
    for (int k = 3; k <= 34; k++) begin
      @(posedge wb_clk_i); #1;
      check("div3_pdm0", 32'(pdm_o[0]), 32'((k >= 16) && ((k % 16) < 4)));
    end

    // back-to-back reads of DIV, LEVEL0 and an unmapped address
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd1;
    @(posedge wb_clk_i); #1;
    check("b2b_ack0", 32'(wb_ack_o), 32'd1);
    check("b2b_div", wb_dat_o, 32'd3);
    wb_adr_i = 5'd2;
    @(posedge wb_clk_i); #1;
    check("b2b_ack1", 32'(wb_ack_o), 32'd1);
    check("b2b_lvl0", wb_dat_o, 32'd64);
    wb_adr_i = 5'd31;
    @(posedge wb_clk_i); #1;
    check("b2b_ack2", 32'(wb_ack_o), 32'd1);
    check("b2b_unmapped", wb_dat_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("b2b_ack_end", 32'(wb_ack_o), 32'd0);

    // unmapped write ignored, level truncated to N bits, DIV upper bits read 0
    wb_write(5'd6, 32'hDEAD_BEEF);
    wb_read_check("unmapped6", 5'd6, 32'd0);
    wb_write(5'd5, 32'hFFFF_FFA5);
    wb_read_check("lvl3_trunc", 5'd5, 32'h0000_00A5);
    wb_write(5'd1, 32'hABCD_0007);
    wb_read_check("div_trunc", 5'd1, 32'h0000_0007);

    // strobe without cycle is not a request
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 5'd4; wb_dat_i = 32'h55;
    @(posedge wb_clk_i); #1;
    check("nocyc_ack", 32'(wb_ack_o), 32'd0);
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_read_check("nocyc_lvl2", 5'd4, 32'd0);

    // INVERT with all channels disabled; COMMIT reads back as 0
    wb_write(5'd0, 32'h8001_0000);
    check("invert_pdm", 32'(pdm_o), 32'h0000_000F);
    wb_read_check("invert_ctrl", 5'd0, 32'h0001_0000);

    // reset mid-stream and mid-transfer
    wb_write(5'd0, 32'h0001_0001);
    check("pre_rst_pdm", 32'(pdm_o[3:1]), 32'h7);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 5'd0;
    @(posedge wb_clk_i); #1;
    check("pre_rst_ack", 32'(wb_ack_o), 32'd1);
    #1 wb_rst_ni = 1'b0;
    #1;
    check("rst_mid_pdm", 32'(pdm_o), 32'd0);
    check("rst_mid_ack", 32'(wb_ack_o), 32'd0);
    check("rst_mid_dat", wb_dat_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); @(posedge wb_clk_i); #3;
    wb_rst_ni = 1'b1;
    wb_read_check("post_ctrl", 5'd0, 32'd0);
    wb_read_check("post_div", 5'd1, 32'd0);
    wb_read_check("post_lvl0", 5'd2, 32'd0);
    wb_read_check("post_lvl1", 5'd3, 32'd0);
    wb_read_check("post_lvl3", 5'd5, 32'd0);
    check("post_pdm", 32'(pdm_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_pdm_multi.md
WB_PDM_MULTI -- requirements
Module: wb_pdm_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning the number of PDM outputs, legal range 1..16.
REQ-002 SHALL have parameter BIT_RESOLUTION, default 8, meaning the level width N, legal range 2..16.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i and wb_we_i, inputs, 1 bit each: Wishbone B4 pipelined slave control.
REQ-006 SHALL have port wb_adr_i, input, 5 bits: word address.
REQ-007 SHALL have port wb_dat_i, input, 32 bits: write data.
REQ-008 SHALL have port wb_dat_o, output, 32 bits: read data, valid while wb_ack_o is high.
REQ-009 SHALL have port wb_ack_o, output, 1 bit: transfer acknowledge.
REQ-010 SHALL have port wb_stall_o, output, 1 bit: tied to 0.
REQ-011 SHALL have port pdm_o, output, CHANNELS bits: PDM bitstreams, bit k is channel k.

Function
REQ-012 SHALL accept a request in every cycle where wb_cyc_i and wb_stb_i are both high, and SHALL assert wb_ack_o exactly one cycle later for each accepted request (back-to-back requests give back-to-back acks).
REQ-013 SHALL use this address map: 0 = CTRL; 1 = DIV; 2+k = LEVEL[k] for k < CHANNELS; every other address is unmapped.
REQ-014 SHALL define CTRL as: bits[CHANNELS-1:0] ENABLE (read/write); bit 16 INVERT (read/write); bit 31 COMMIT (write-1 strobe, reads 0); all other bits read 0.
REQ-015 SHALL define DIV as bits[15:0] read/write, with other bits reading 0; a write to DIV SHALL also clear the prescaler counter.
REQ-016 SHALL write LEVEL[k] into a shadow register, bits[N-1:0]; a read of LEVEL[k] SHALL return the shadow value, zero-extended.
REQ-017 SHALL acknowledge unmapped addresses, return 0 on reads to them and ignore writes to them.
REQ-018 SHALL, on a CTRL write with bit 31 set, copy all shadow levels into the active levels at that clock edge; the new values apply from the next tick.
REQ-019 SHALL generate a prescaler tick when the counter equals DIV, then reset the counter to 0; otherwise the counter increments; DIV = 0 gives a tick every cycle.
REQ-020 SHALL update each enabled channel on a tick as acc <= acc[N-1:0] + active_level, where acc is N+1 bits wide; the carry is not saturated.
REQ-021 SHALL force the accumulator of a disabled channel to 0 each cycle.
REQ-022 SHALL drive pdm_o[k] = acc[N] XOR INVERT, registered, with no extra pipeline stage; a disabled channel therefore outputs INVERT.
REQ-023 SHALL, when COMMIT and a tick occur in the same cycle, apply the tick with the old active levels.
REQ-024 SHALL, when an ENABLE bit rises, start that channel from acc = 0.
REQ-025 SHALL give the average density of channel k as active_level/2^N; level 0 outputs a constant 0 and level 2^N-1 outputs 0 once every 2^N ticks.
REQ-026 SHALL complete writes that are acked after wb_cyc_i falls, but SHALL NOT accept any request while wb_cyc_i is low.

Reset
REQ-027 SHALL, while wb_rst_ni is low, clear immediately: CTRL, DIV, the prescaler counter, all shadow and active levels, all accumulators, wb_ack_o, wb_dat_o and pdm_o (to 0).
REQ-028 SHALL, when reset is asserted mid-transfer, drop the pending ack; the first accepted request after release is acked normally.

Structure
REQ-029 SHALL place the address constants, CTRL bit positions and the 32-bit data width in a shared package wb_pdm_pkg.
REQ-030 SHALL implement each channel in one sub-module, wb_pdm_modulator, with ports clock, reset, tick, enable, level and out; it is instantiated CHANNELS times.

Verification
REQ-031 SHALL cover: N=8, DIV=0, LEVEL0=64, ENABLE=1, COMMIT -> pdm_o[0] first high 4 ticks after COMMIT, then period 4 with 1 high.
REQ-032 SHALL cover: DIV=3 with the REQ-031 setup -> tick every 4 clocks; the pdm_o[0] high pulse lasts 4 clocks every 16 clocks.
REQ-033 SHALL cover: LEVEL1=128 written without COMMIT -> pdm_o[1] stays 0; after COMMIT -> alternating 0/1.
REQ-034 SHALL cover: INVERT=1 with all channels disabled -> pdm_o all ones; a read of CTRL returns 0x0001_0000.
REQ-035 SHALL cover: 3 back-to-back reads of addresses 1, 2 and 31 -> 3 consecutive acks returning DIV, LEVEL0 and 0.
REQ-036 SHALL cover: wb_rst_ni pulsed low mid-stream -> pdm_o is 0 the same cycle and all registers read 0 afterwards.
